// File: rtl/dequantizer.sv
// Streaming dequantizer: signed activations -> signed accumulator-domain values via per-channel scale/zero-point tables.
// Latency: 2 cycles (beat presented in cycle c appears with out_valid in cycle c+2), one beat per cycle sustained.
// Backpressure: valid/ready both sides; holds at most 2 beats while out_ready=0, in_ready is combinational from out_ready only.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cfg_we/cfg_addr/cfg_scale/cfg_zp  per-channel table write (addresses >= NUM_CH ignored)
//   in_valid/in_ready/in_data/in_last input stream; in_last returns the channel counter to 0
//   out_valid/out_ready/out_data/out_sat output stream; out_sat flags a clamped value
// Optional feature: define DEQUANT_SAT_EN to clamp to the ACC range instead of wrapping.

`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef ACC_WIDTH
`define ACC_WIDTH 16
`endif

module dequantizer #(
    parameter int NUM_CH      = 4,
    parameter int SCALE_WIDTH = 8,
    parameter int SHIFT       = 0,
    localparam int CW         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_we,
    input  logic [CW-1:0]                 cfg_addr,
    input  logic signed [SCALE_WIDTH-1:0] cfg_scale,
    input  logic signed [`DATA_WIDTH-1:0] cfg_zp,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [`DATA_WIDTH-1:0] in_data,
    input  logic                          in_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [`ACC_WIDTH-1:0]  out_data,
    output logic                          out_sat
);

    localparam int DW = `DATA_WIDTH;
    localparam int AW = `ACC_WIDTH;
    localparam int PW = DW + 1 + SCALE_WIDTH;
    // Intermediate is wide enough to hold the shifted product losslessly and
    // always at least one bit wider than the output so the clamp compare works.
    localparam int WW = ((PW + SHIFT) > (AW + 1)) ? (PW + SHIFT) : (AW + 1);

    // Per-channel tables
    logic signed [SCALE_WIDTH-1:0] r_scale_tab [NUM_CH];
    logic signed [DW-1:0]          r_zp_tab    [NUM_CH];
    logic [CW-1:0]                 r_ch;

    // Stage 1 registers
    logic                          r_s1_vld;
    logic signed [DW:0]            r_diff;
    logic signed [SCALE_WIDTH-1:0] r_s1_scale;

    // Stage 2 (output) registers
    logic                          r_out_vld;
    logic signed [AW-1:0]          r_out_data;

    logic                          w_accept;
    logic                          w_s2_en;
    logic signed [DW:0]            w_diff;
    logic signed [DW-1:0]          w_zp_sel;
    logic signed [PW-1:0]          w_prod;
    logic signed [WW-1:0]          w_wide;
    logic signed [AW-1:0]          w_red;
    logic [CW-1:0]                 w_ch_next;

    // Output register can load when empty or being drained this cycle.
    assign w_s2_en  = !r_out_vld || out_ready;
    assign in_ready = !r_s1_vld || w_s2_en;
    assign w_accept = in_valid && in_ready;

    assign w_ch_next = (in_last || (r_ch == CW'(NUM_CH - 1))) ? '0 : r_ch + CW'(1);

    // Sign-extend both operands by one bit so the subtraction cannot overflow.
    assign w_zp_sel = r_zp_tab[r_ch];
    assign w_diff   = $signed({in_data[DW-1], in_data}) - $signed({w_zp_sel[DW-1], w_zp_sel});

    // Size casts of signed operands sign-extend, giving a full-precision product.
    assign w_prod = PW'(r_diff) * PW'(r_s1_scale);
    assign w_wide = WW'(w_prod) <<< SHIFT;

`ifdef DEQUANT_SAT_EN
    localparam logic signed [WW-1:0] MAXV = {{(WW - AW + 1){1'b0}}, {(AW - 1){1'b1}}};
    localparam logic signed [WW-1:0] MINV = {{(WW - AW + 1){1'b1}}, {(AW - 1){1'b0}}};

    logic w_sat;
    logic r_out_sat;

    always_comb begin
        w_sat = 1'b0;
        w_red = AW'(w_wide);
        if (w_wide > MAXV) begin
            w_sat = 1'b1;
            w_red = AW'(MAXV);
        end else if (w_wide < MINV) begin
            w_sat = 1'b1;
            w_red = AW'(MINV);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_sat <= 1'b0;
        end else if (w_s2_en && r_s1_vld) begin
            r_out_sat <= w_sat;
        end
    end

    assign out_sat = r_out_sat;
`else
    // Two's-complement wrap: keep the low ACC bits.
    assign w_red   = AW'(w_wide);
    assign out_sat = 1'b0;
`endif

    // Table writes: a beat accepted in the same cycle reads the old entry,
    // since the read above uses the pre-edge table contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_scale_tab[i] <= SCALE_WIDTH'(1);
                r_zp_tab[i]    <= '0;
            end
        end else if (cfg_we && (int'(cfg_addr) < NUM_CH)) begin
            r_scale_tab[cfg_addr] <= cfg_scale;
            r_zp_tab[cfg_addr]    <= cfg_zp;
        end
    end

    // Stage 1: subtract zero-point, capture scale, advance channel.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ch       <= '0;
            r_s1_vld   <= 1'b0;
            r_diff     <= '0;
            r_s1_scale <= '0;
        end else begin
            if (w_accept) begin
                r_ch       <= w_ch_next;
                r_diff     <= w_diff;
                r_s1_scale <= r_scale_tab[r_ch];
                r_s1_vld   <= 1'b1;
            end else if (w_s2_en) begin
                r_s1_vld   <= 1'b0;
            end
        end
    end

    // Stage 2: multiply, shift, reduce into the output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_vld  <= 1'b0;
            r_out_data <= '0;
        end else if (w_s2_en) begin
            r_out_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_out_data <= w_red;
            end
        end
    end

    assign out_valid = r_out_vld;
    assign out_data  = r_out_data;

endmodule

// File: tb/tb_dequantizer.sv
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef ACC_WIDTH
`define ACC_WIDTH 16
`endif

module tb_dequantizer;

    logic                          clk = 1'b0;
    logic                          rst;
    logic                          cfg_we;
    logic [1:0]                    cfg_addr;
    logic signed [7:0]             cfg_scale;
    logic signed [`DATA_WIDTH-1:0] cfg_zp;
    logic                          in_valid;
    logic signed [`DATA_WIDTH-1:0] in_data;
    logic                          in_last;
    logic                          out_ready;

    logic                          in_ready0, in_ready1;
    logic                          out_valid0, out_valid1;
    logic signed [`ACC_WIDTH-1:0]  out_data0, out_data1;
    logic                          out_sat0, out_sat1;

    always #5 clk = ~clk;

    dequantizer #(.NUM_CH(4), .SCALE_WIDTH(8), .SHIFT(0)) dut_s0 (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_scale(cfg_scale), .cfg_zp(cfg_zp),
        .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .out_sat(out_sat0)
    );

    dequantizer #(.NUM_CH(4), .SCALE_WIDTH(8), .SHIFT(1)) dut_s1 (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_scale(cfg_scale), .cfg_zp(cfg_zp),
        .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .out_sat(out_sat1)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the dequantization rule.
    function automatic longint ref_val(input int d, input int zp, input int sc, input int sh,
                                       output bit sat);
        longint v, hi, lo, span;
        hi   = (longint'(1) << (`ACC_WIDTH - 1)) - 1;
        lo   = -hi - 1;
        span = 2 * (hi + 1);
        v    = longint'(d - zp) * longint'(sc) * (longint'(1) << sh);
        sat  = 1'b0;
`ifdef DEQUANT_SAT_EN
        if (v > hi) begin
            v = hi; sat = 1'b1;
        end else if (v < lo) begin
            v = lo; sat = 1'b1;
        end
`else
        v = v % span;
        if (v > hi) v -= span;
        else if (v < lo) v += span;
`endif
        return v;
    endfunction

    typedef struct {
        longint d0;
        longint d1;
        bit     s0;
        bit     s1;
        int     cyc;
    } exp_t;

    exp_t q[$];
    int   m_sc[4];
    int   m_zp[4];
    int   m_ch;
    int   cyc;
    bit   post_rst;

    // Model + scoreboard: evaluated mid-cycle, then advanced to reflect the coming edge.
    initial begin
        bit     exp_rdy, exp_vld;
        exp_t   e;
        cyc = 0;
        post_rst = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                q.delete();
                for (int i = 0; i < 4; i++) begin
                    m_sc[i] = 1;
                    m_zp[i] = 0;
                end
                m_ch = 0;
                post_rst = 1'b1;
            end else begin
                exp_rdy = (q.size() < 2) || out_ready;
                exp_vld = (q.size() > 0) && (cyc >= q[0].cyc + 2);
                check("in_ready_s0", in_ready0, exp_rdy);
                check("in_ready_s1", in_ready1, exp_rdy);
                check("out_valid_s0", out_valid0, exp_vld);
                check("out_valid_s1", out_valid1, exp_vld);
                if (post_rst) begin
                    check("rst_data_s0", out_data0, 0);
                    check("rst_data_s1", out_data1, 0);
                    check("rst_sat_s0", out_sat0, 0);
                    check("rst_sat_s1", out_sat1, 0);
                    post_rst = 1'b0;
                end
                if (exp_vld) begin
                    check("data_s0", out_data0, q[0].d0);
                    check("data_s1", out_data1, q[0].d1);
                    check("sat_s0", out_sat0, q[0].s0);
                    check("sat_s1", out_sat1, q[0].s1);
                    if (out_ready) void'(q.pop_front());
                end
                if (in_valid && exp_rdy) begin
                    e.d0  = ref_val(int'(in_data), m_zp[m_ch], m_sc[m_ch], 0, e.s0);
                    e.d1  = ref_val(int'(in_data), m_zp[m_ch], m_sc[m_ch], 1, e.s1);
                    e.cyc = cyc;
                    q.push_back(e);
                    m_ch = (in_last || m_ch == 3) ? 0 : m_ch + 1;
                end
                if (cfg_we) begin
                    m_sc[cfg_addr] = int'(cfg_scale);
                    m_zp[cfg_addr] = int'(cfg_zp);
                end
            end
        end
    end

    task automatic step(input bit v, input int d, input bit l, input bit ordy);
        in_valid  = v;
        in_data   = d[`DATA_WIDTH-1:0];
        in_last   = l;
        out_ready = ordy;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic set_cfg(input int addr, input int sc, input int zp);
        cfg_we    = 1'b1;
        cfg_addr  = addr[1:0];
        cfg_scale = sc[7:0];
        cfg_zp    = zp[`DATA_WIDTH-1:0];
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 1'b1);
    endtask

    initial begin
        int vals[4];
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_scale = '0; cfg_zp = '0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        idle(1);

        // Identity defaults across the signed range
        vals = '{-128, -1, 0, 127};
        foreach (vals[i]) step(1'b1, vals[i], 1'b0, 1'b1);
        idle(4);

        // Per-channel tables with channel wrap
        set_cfg(0, 3, 2);   idle(1);
        set_cfg(1, -2, -5); idle(1);
        set_cfg(2, 1, 0);   idle(1);
        set_cfg(3, 10, 0);  idle(1);
        for (int i = 0; i < 5; i++) step(1'b1, 10, 1'b0, 1'b1);
        idle(3);

        // in_last resets the counter (counter is at 1 after the wrap above)
        step(1'b1, 0, 1'b1, 1'b1);
        step(1'b1, 10, 1'b0, 1'b1);
        step(1'b1, 10, 1'b1, 1'b1);
        step(1'b1, 10, 1'b0, 1'b1);
        idle(3);

        // Saturation / wrap corner on ch0
        step(1'b1, 0, 1'b1, 1'b1);
        set_cfg(0, 127, -128); idle(1);
        step(1'b1, 127, 1'b1, 1'b1);
        idle(3);

        // Backpressure: pipeline fills to 2 then stalls
        for (int i = 0; i < 6; i++) step(1'b1, 20 + i, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 40 + i, 1'b0, 1'b1);
        idle(4);

        // Table write coinciding with a ch1 beat
        step(1'b1, 0, 1'b1, 1'b1);
        set_cfg(0, 3, 2); step(1'b1, 5, 1'b0, 1'b1);
        set_cfg(1, 7, 0); step(1'b1, 5, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 5, 1'b0, 1'b1);
        step(1'b1, 5, 1'b0, 1'b1);
        idle(3);

        // Reset with two beats in flight
        step(1'b1, 1, 1'b0, 1'b0);
        step(1'b1, 2, 1'b0, 1'b0);
        rst = 1'b1; step(1'b0, 0, 1'b0, 1'b1); rst = 1'b0;
        idle(1);
        set_cfg(0, 2, 0); idle(1);
        step(1'b1, 9, 1'b0, 1'b1);
        step(1'b1, 9, 1'b0, 1'b1);
        step(1'b1, -9, 1'b0, 1'b1);
        idle(3);

        // Randomized traffic with config writes and occasional reset
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 9) == 0)
                set_cfg($urandom_range(0, 3), int'($urandom_range(0, 255)) - 128,
                        int'($urandom_range(0, 255)) - 128);
            if ($urandom_range(0, 299) == 0) rst = 1'b1;
            step($urandom_range(0, 3) != 0, int'($urandom_range(0, 255)) - 128,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0);
            rst = 1'b0;
        end

        idle(6);
        check("drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
